// File: rtl/rgb2yuv_packer.sv
// RGB888 -> BT.601 YUV 4:2:2 packer: three-stage pipeline ending in a pixel-pair FSM, output word {V, Y0, U, Y1}.
// Define RGB2YUV_STATS_EN to add the word_cnt / odd_cnt statistics outputs.
module rgb2yuv_packer #(
  parameter int Y_OFFSET = 16,
  parameter int C_OFFSET = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] in_rgb,
  input  logic        in_sol,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_yuv,
  output logic        out_valid,
`ifdef RGB2YUV_STATS_EN
  output logic [15:0] word_cnt,
  output logic [15:0] odd_cnt,
`endif
  input  logic        out_ready
);

  typedef enum logic {EVEN, ODD} pair_state_t;

  function automatic logic [7:0] scale_off(input logic signed [19:0] sum, input int offset);
    return 8'((sum >>> 8) + 20'(offset));
  endfunction

  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    return 8'(({1'b0, a} + {1'b0, b}) >> 1);
  endfunction

  // Reset asserts asynchronously and is released on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_i = rst_sync[1];

  logic stall, accept;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  logic signed [17:0] r_s, g_s, b_s;
  assign r_s = {10'd0, in_rgb[23:16]};
  assign g_s = {10'd0, in_rgb[15:8]};
  assign b_s = {10'd0, in_rgb[7:0]};

  // Stage 1: coefficient products
  logic signed [17:0] ry_p1, gy_p1, by_p1, ru_p1, gu_p1, bu_p1, rv_p1, gv_p1, bv_p1;
  logic               sol_p1, vld_p1;
  always_ff @(posedge clk) begin
    if (!stall) begin
      ry_p1  <= r_s * 18'sd66;
      gy_p1  <= g_s * 18'sd129;
      by_p1  <= b_s * 18'sd25;
      ru_p1  <= r_s * 18'sd38;
      gu_p1  <= g_s * 18'sd74;
      bu_p1  <= b_s * 18'sd112;
      rv_p1  <= r_s * 18'sd112;
      gv_p1  <= g_s * 18'sd94;
      bv_p1  <= b_s * 18'sd18;
      sol_p1 <= in_sol;
    end
  end

  // Stage 2: sum, round, shift, offset
  logic signed [19:0] y_sum, u_sum, v_sum;
  assign y_sum = 20'(ry_p1) + 20'(gy_p1) + 20'(by_p1) + 20'sd128;
  assign u_sum = 20'(bu_p1) - 20'(ru_p1) - 20'(gu_p1) + 20'sd128;
  assign v_sum = 20'(rv_p1) - 20'(gv_p1) - 20'(bv_p1) + 20'sd128;

  logic [7:0] y_p2, u_p2, v_p2;
  logic       sol_p2, vld_p2;
  always_ff @(posedge clk) begin
    if (!stall) begin
      y_p2   <= scale_off(y_sum, Y_OFFSET);
      u_p2   <= scale_off(u_sum, C_OFFSET);
      v_p2   <= scale_off(v_sum, C_OFFSET);
      sol_p2 <= sol_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (!stall) begin
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
    end
  end

  // Stage 3: pair FSM and packing
  pair_state_t state_p3;
  logic [7:0]  y0_p3, u0_p3, v0_p3;
  logic        emit_vld, emit_odd;
  logic [31:0] emit_word;

  always_comb begin
    emit_vld  = 1'b0;
    emit_odd  = 1'b0;
    emit_word = '0;
    if (vld_p2 && state_p3 == ODD) begin
      emit_vld = 1'b1;
      if (sol_p2) begin
        emit_odd  = 1'b1;
        emit_word = {v0_p3, y0_p3, u0_p3, y0_p3};
      end else begin
        emit_word = {avg8(v0_p3, v_p2), y0_p3, avg8(u0_p3, u_p2), y_p2};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!stall && vld_p2 && (state_p3 == EVEN || sol_p2)) begin
      y0_p3 <= y_p2;
      u0_p3 <= u_p2;
      v0_p3 <= v_p2;
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_p3 <= EVEN;
    end else if (!stall && vld_p2) begin
      case (state_p3)
        EVEN:    state_p3 <= ODD;
        default: state_p3 <= sol_p2 ? ODD : EVEN;
      endcase
    end
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid <= 1'b0;
      out_yuv   <= '0;
    end else if (!stall) begin
      out_valid <= emit_vld;
      if (emit_vld) out_yuv <= emit_word;
    end
  end

`ifdef RGB2YUV_STATS_EN
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      word_cnt <= '0;
      odd_cnt  <= '0;
    end else begin
      if (out_valid && out_ready) word_cnt <= word_cnt + 16'd1;
      if (!stall && emit_odd)     odd_cnt  <= odd_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rgb2yuv_packer.sv
// Scoreboard bench for rgb2yuv_packer: a pixel-level reference model queues expected words, a monitor checks output handshakes.
module tb_rgb2yuv_packer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] in_rgb = '0;
  logic        in_sol = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_yuv;
  logic        out_valid;
  logic        out_ready;
`ifdef RGB2YUV_STATS_EN
  logic [15:0] word_cnt, odd_cnt;
`endif

  rgb2yuv_packer dut (
    .clk(clk), .rst_n(rst_n), .in_rgb(in_rgb), .in_sol(in_sol), .in_valid(in_valid),
    .in_ready(in_ready), .out_yuv(out_yuv), .out_valid(out_valid),
`ifdef RGB2YUV_STATS_EN
    .word_cnt(word_cnt), .odd_cnt(odd_cnt),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int hs_n = 0;
  int hs_cyc[$];
  int rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low
  bit model_en = 1'b1;
  logic [31:0] exp_q[$];

  bit         held_v = 1'b0;
  logic [7:0] hy, hu, hv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // BT.601 conversion straight from the integer formulas
  task automatic to_yuv(input logic [23:0] p, output logic [7:0] y, output logic [7:0] u, output logic [7:0] v);
    int r, g, b;
    r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
    y = 8'(((66 * r + 129 * g + 25 * b + 128) >>> 8) + 16);
    u = 8'(((-38 * r - 74 * g + 112 * b + 128) >>> 8) + 128);
    v = 8'(((112 * r - 94 * g - 18 * b + 128) >>> 8) + 128);
  endtask

  task automatic model_pixel(input logic [23:0] p, input logic sol);
    logic [7:0] y, u, v;
    to_yuv(p, y, u, v);
    if (!held_v) begin
      held_v = 1'b1; hy = y; hu = u; hv = v;
    end else if (sol) begin
      exp_q.push_back({hv, hy, hu, hy});
      hy = y; hu = u; hv = v;
    end else begin
      exp_q.push_back({8'((int'(hv) + int'(v)) / 2), hy, 8'((int'(hu) + int'(u)) / 2), y});
      held_v = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #2;
    case (rdy_mode)
      1:       out_ready = ($urandom_range(0, 3) != 0);
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: sample mid-cycle, pop and compare on each handshake
  logic        prev_stall = 1'b0;
  logic [31:0] prev_word = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !out_ready) begin
        check("in_ready_during_stall", {31'd0, in_ready}, 32'd0);
        if (prev_stall) check("out_yuv_stable", out_yuv, prev_word);
      end
      if (out_valid && out_ready) begin
        hs_n++;
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_word", out_yuv, 32'hxxxxxxxx);
        else check("word", out_yuv, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = out_yuv;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send_pixel(input logic [23:0] p, input logic sol);
    bit done = 1'b0;
    in_rgb = p; in_sol = sol; in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (model_en) model_pixel(p, sol);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; in_sol = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_yuv", out_yuv, 32'd0);
    exp_q.delete();
    held_v = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_empty", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int base, n;
    bit seen;
    repeat (3) @(posedge clk);
    #1;

    // Black then white: one word, latency and single-cycle pulse
    model_en = 1'b0;
    do_reset();
    exp_q.push_back(32'h801080EB);
    send_pixel(24'h000000, 1'b0);
    send_pixel(24'hFFFFFF, 1'b0);
    @(negedge clk); check("lat_cyc1", {31'd0, out_valid}, 32'd0);
    @(negedge clk); check("lat_cyc2", {31'd0, out_valid}, 32'd0);
    @(negedge clk); check("lat_cyc3", {31'd0, out_valid}, 32'd1);
    @(negedge clk); check("pulse_end", {31'd0, out_valid}, 32'd0);
    drain();

    // Red then blue
    do_reset();
    exp_q.push_back(32'hAF52A529);
    send_pixel(24'hFF0000, 1'b0);
    send_pixel(24'h0000FF, 1'b0);
    drain();

    // Odd flush on sol
    do_reset();
    exp_q.push_back(32'hF0525A52);
    exp_q.push_back(32'h80108010);
    send_pixel(24'hFF0000, 1'b0);
    send_pixel(24'h000000, 1'b1);
    send_pixel(24'h000000, 1'b0);
    drain();
`ifdef RGB2YUV_STATS_EN
    check("odd_cnt", {16'd0, odd_cnt}, 32'd1);
    check("word_cnt", {16'd0, word_cnt}, 32'd2);
`endif

    // Backpressure: hold out_ready low for 5 cycles while a word is valid
    model_en = 1'b1;
    do_reset();
    rdy_mode = 2;
    fork
      begin
        for (int i = 0; i < 40; i++) send_pixel(24'($urandom), 1'b0);
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
          @(negedge clk);
          if (out_valid) seen = 1'b1;
        end
        check("stall_word_seen", {31'd0, seen}, 32'd1);
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        rdy_mode = 0;
      end
    join
    drain();
    n = hs_cyc.size();
    for (int k = n - 4; k < n; k++) check("throughput_gap", hs_cyc[k] - hs_cyc[k-1], 2);

    // Reset with held and in-flight pixels, then white, white
    do_reset();
    send_pixel(24'h123456, 1'b0);
    send_pixel(24'h654321, 1'b0);
    send_pixel(24'hABCDEF, 1'b0);
    rst_n = 1'b0;
    model_en = 1'b0;
    do_reset();
    exp_q.push_back(32'h80EB80EB);
    send_pixel(24'hFFFFFF, 1'b0);
    send_pixel(24'hFFFFFF, 1'b0);
    drain();

    // Two back-to-back 640-pixel lines
    model_en = 1'b1;
    do_reset();
    base = hs_n;
    for (int l = 0; l < 2; l++)
      for (int p = 0; p < 640; p++) send_pixel(24'($urandom), p == 0);
    drain();
    check("line_words", hs_n - base, 640);
`ifdef RGB2YUV_STATS_EN
    check("line_odd_cnt", {16'd0, odd_cnt}, 32'd0);
`endif

    // Random pixels, sol and backpressure
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      send_pixel(24'($urandom), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    rdy_mode = 0;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
